// File: rtl/pe_link_arbiter.sv
// pe_link_arbiter
// ---------------
// Credit-based round-robin arbiter that shares one 20-bit processing-element
// injection link between four local flit sources. One source is granted per
// cycle, and only while a downstream buffer credit is available. The winning
// flit is registered onto the link. Credits come back on 'ci', one per cycle
// that it is high.
//
// Compile-time option:
//   PE_ARB_PKT_LOCK_EN  When defined, the arbiter does wormhole locking. A
//                       granted head flit locks the link to its source until
//                       that source's tail (or a single) flit is granted.
//                       When undefined, the flit type bits are ignored and
//                       every grant advances the round-robin pointer.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   req         per-source flit valid, held with its flit until granted
//   flit0..3    source flits; [19:18] = type (10 head, 00 body, 01 tail,
//               11 single)
//   ci          credit return, one credit per cycle high
//   gnt         one-hot combinational grant; the flit is consumed this cycle
//   dataout     registered link flit
//   out_valid   registered; high for the cycle dataout carries a new flit
//   credit_cnt  currently available downstream credits
//   err_ovf     sticky overflow flag (credit returned while already full)

module pe_link_arbiter #(
    parameter int N_REQ   = 4,
    parameter int CREDITS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [19:0]      flit0,
    input  logic [19:0]      flit1,
    input  logic [19:0]      flit2,
    input  logic [19:0]      flit3,
    input  logic             ci,
    output logic [N_REQ-1:0] gnt,
    output logic [19:0]      dataout,
    output logic             out_valid,
    output logic [2:0]       credit_cnt,
    output logic             err_ovf
);

    logic [1:0]       rr_ptr;
    logic [N_REQ-1:0] eligible;
    logic [1:0]       winner;
    logic [1:0]       search_idx;
    logic             any_grant;
    logic [19:0]      flit_sel;

`ifdef PE_ARB_PKT_LOCK_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [1:0] FT_HEAD   = 2'b10;
    localparam logic [1:0] FT_TAIL   = 2'b01;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    logic [0:0]       state;
    logic [1:0]       own;
    logic [N_REQ-1:0] own_mask;
    logic [1:0]       flit_type;

    // While a packet owns the link only its source may compete, so a
    // packet's flits are never interleaved with another source's flits.
    always_comb begin
        own_mask      = '0;
        own_mask[own] = 1'b1;
        if (state == ST_LOCKED) begin
            eligible = req & own_mask;
        end else begin
            eligible = req;
        end
    end
`else
    // Per-flit arbitration: every request competes on every cycle.
    always_comb begin
        eligible = req;
    end
`endif

    // Round-robin search starting at rr_ptr and wrapping modulo 4. Nothing
    // is granted during reset or with no credit left; a credit arriving this
    // cycle only becomes usable next cycle, since the search looks at the
    // registered count.
    always_comb begin
        any_grant  = 1'b0;
        winner     = 2'd0;
        search_idx = 2'd0;
        gnt        = '0;
        if (!rst && credit_cnt != 3'd0) begin
            for (int k = 0; k < N_REQ; k++) begin
                search_idx = rr_ptr + 2'(k);
                if (!any_grant && eligible[search_idx]) begin
                    any_grant = 1'b1;
                    winner    = search_idx;
                end
            end
        end
        if (any_grant) begin
            gnt[winner] = 1'b1;
        end
    end

    // Selects the winning source's flit for the output register and for
    // the flit-type decode used by the packet lock.
    always_comb begin
        case (winner)
            2'd0:    flit_sel = flit0;
            2'd1:    flit_sel = flit1;
            2'd2:    flit_sel = flit2;
            default: flit_sel = flit3;
        endcase
    end

    // Credit counter: a send consumes one credit and a return restores one;
    // both together cancel out. A return while already full is an upstream
    // protocol error: the count holds and the sticky flag is raised. It
    // cannot underflow because nothing is granted at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= 3'(CREDITS);
            err_ovf    <= 1'b0;
        end else begin
            if (any_grant && !ci) begin
                credit_cnt <= credit_cnt - 3'd1;
            end else if (ci && !any_grant) begin
                if (credit_cnt == 3'(CREDITS)) begin
                    err_ovf <= 1'b1;
                end else begin
                    credit_cnt <= credit_cnt + 3'd1;
                end
            end
        end
    end

    // Link output register. dataout keeps its last flit when idle, so only
    // out_valid tells the router whether a new flit is present.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataout   <= 20'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= any_grant;
            if (any_grant) begin
                dataout <= flit_sel;
            end
        end
    end

`ifdef PE_ARB_PKT_LOCK_EN
    assign flit_type = flit_sel[19:18];

    // Wormhole FSM. A head flit locks the link to its source without moving
    // the pointer. The pointer moves only when a grant releases the link:
    // a single/body/tail grant in IDLE, or a tail/single grant in LOCKED.
    // Reset drops any lock in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            own    <= 2'd0;
            rr_ptr <= 2'd0;
        end else if (any_grant) begin
            case (state)
                ST_IDLE: begin
                    if (flit_type == FT_HEAD) begin
                        state <= ST_LOCKED;
                        own   <= winner;
                    end else begin
                        rr_ptr <= winner + 2'd1;
                    end
                end
                default: begin
                    if (flit_type == FT_TAIL || flit_type == FT_SINGLE) begin
                        state  <= ST_IDLE;
                        rr_ptr <= own + 2'd1;
                    end
                end
            endcase
        end
    end
`else
    // Without packet locking the pointer moves past the winner after every
    // grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (any_grant) begin
            rr_ptr <= winner + 2'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_link_arbiter.sv
// tb_pe_link_arbiter
// ------------------
// Directed testbench for pe_link_arbiter. Each task drives one scenario and
// compares the DUT against hand-computed expected values. Inputs change one
// time unit after the rising edge. Combinational grants are sampled before
// the next edge. Registered outputs are sampled one time unit after the edge.
// Expected packet-lock behaviour follows PE_ARB_PKT_LOCK_EN.

module tb_pe_link_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [19:0] fl [4];
    logic        ci;
    logic [3:0]  gnt;
    logic [19:0] dataout;
    logic        out_valid;
    logic [2:0]  credit_cnt;
    logic        err_ovf;

    int checks;
    int errors;

    pe_link_arbiter #(
        .N_REQ   (4),
        .CREDITS (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .flit0      (fl[0]),
        .flit1      (fl[1]),
        .flit2      (fl[2]),
        .flit3      (fl[3]),
        .ci         (ci),
        .gnt        (gnt),
        .dataout    (dataout),
        .out_valid  (out_valid),
        .credit_cnt (credit_cnt),
        .err_ovf    (err_ovf)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Moves one time unit past the next rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Returns the DUT to its reset state with idle inputs.
    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        ci  = 1'b0;
        for (int i = 0; i < 4; i++) fl[i] = 20'd0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 4'b1111;
        ci  = 1'b1;
        for (int i = 0; i < 4; i++) fl[i] = {2'b11, 18'h00100 + 18'(i)};
        step();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt);
        end
        step();
        checks++;
        if (credit_cnt !== 3'd7) begin
            errors++;
            $display("[TB] FAIL reset_credit: got %0d expected 7", credit_cnt);
        end
        checks++;
        if (out_valid !== 1'b0 || dataout !== 20'd0) begin
            errors++;
            $display("[TB] FAIL reset_out: got valid %b data %h expected 0 00000",
                     out_valid, dataout);
        end
        checks++;
        if (err_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_err_ovf: got %b expected 0", err_ovf);
        end
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_gnt_held: got %b expected 0000", gnt);
        end
        rst = 1'b0;
        req = 4'b0000;
        ci  = 1'b0;
        step();
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_gnt;
        int         w;
        for (int i = 0; i < 4; i++) fl[i] = {2'b11, 18'h00100 + 18'(i)};
        req = 4'b1111;
        ci  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            w       = c % 4;
            exp_gnt = 4'b0001 << w;
            #1;
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("[TB] FAIL rr_gnt cycle %0d: got %b expected %b", c, gnt, exp_gnt);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || dataout !== fl[w]) begin
                errors++;
                $display("[TB] FAIL rr_data cycle %0d: got valid %b data %h expected 1 %h",
                         c, out_valid, dataout, fl[w]);
            end
            checks++;
            if (credit_cnt !== 3'd7) begin
                errors++;
                $display("[TB] FAIL rr_credit cycle %0d: got %0d expected 7", c, credit_cnt);
            end
        end
        req = 4'b0000;
        ci  = 1'b0;
    endtask

    task automatic test_credit_exhaust;
        logic [3:0] exp_gnt;
        logic [2:0] exp_cnt;
        fl[2] = {2'b11, 18'h2AAAA};
        req   = 4'b0100;
        ci    = 1'b0;
        for (int c = 0; c < 9; c++) begin
            exp_gnt = (c < 7) ? 4'b0100 : 4'b0000;
            exp_cnt = (c < 7) ? 3'(6 - c) : 3'd0;
            #1;
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("[TB] FAIL exhaust_gnt cycle %0d: got %b expected %b", c, gnt, exp_gnt);
            end
            step();
            checks++;
            if (credit_cnt !== exp_cnt || out_valid !== (c < 7)) begin
                errors++;
                $display("[TB] FAIL exhaust_cnt cycle %0d: got cnt %0d valid %b expected %0d %b",
                         c, credit_cnt, out_valid, exp_cnt, (c < 7));
            end
        end
        // Credit returned at zero with a request pending: no grant yet.
        ci = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL zero_ci_gnt: got %b expected 0000", gnt);
        end
        step();
        checks++;
        if (credit_cnt !== 3'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_ci_cnt: got cnt %0d valid %b expected 1 0",
                     credit_cnt, out_valid);
        end
        ci = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL after_ci_gnt: got %b expected 0100", gnt);
        end
        step();
        checks++;
        if (credit_cnt !== 3'd0 || out_valid !== 1'b1 || dataout !== fl[2]) begin
            errors++;
            $display("[TB] FAIL after_ci_out: got cnt %0d valid %b data %h expected 0 1 %h",
                     credit_cnt, out_valid, dataout, fl[2]);
        end
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL after_ci_idle_gnt: got %b expected 0000", gnt);
        end
        req = 4'b0000;
    endtask

    task automatic test_packet_lock;
        logic [19:0] pkt [4];
        int          exp_w [7];
        int          g1;
        logic [3:0]  exp_gnt;
        logic [19:0] exp_data;
        do_reset();
`ifdef PE_ARB_PKT_LOCK_EN
        exp_w = '{1, 1, 1, 1, 3, 3, 3};
`else
        exp_w = '{1, 3, 1, 3, 1, 3, 1};
`endif
        pkt[0] = {2'b10, 18'h11111};
        pkt[1] = {2'b00, 18'h22222};
        pkt[2] = {2'b00, 18'h33333};
        pkt[3] = {2'b01, 18'h04444};
        fl[3]  = {2'b11, 18'h3CCCC};
        g1     = 0;
        ci     = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req   = {1'b1, 1'b0, (g1 < 4), 1'b0};
            fl[1] = pkt[(g1 < 4) ? g1 : 3];
            exp_gnt  = 4'b0001 << exp_w[c];
            exp_data = fl[exp_w[c]];
            #1;
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("[TB] FAIL lock_gnt cycle %0d: got %b expected %b", c, gnt, exp_gnt);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || dataout !== exp_data) begin
                errors++;
                $display("[TB] FAIL lock_data cycle %0d: got valid %b data %h expected 1 %h",
                         c, out_valid, dataout, exp_data);
            end
            if (exp_w[c] == 1) g1++;
        end
        req = 4'b0000;
        ci  = 1'b0;
    endtask

    task automatic test_overflow;
        do_reset();
        checks++;
        if (err_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_initial: got %b expected 0", err_ovf);
        end
        ci = 1'b1;
        step();
        ci = 1'b0;
        checks++;
        if (err_ovf !== 1'b1 || credit_cnt !== 3'd7) begin
            errors++;
            $display("[TB] FAIL ovf_set: got err %b cnt %0d expected 1 7", err_ovf, credit_cnt);
        end
        step();
        step();
        step();
        checks++;
        if (err_ovf !== 1'b1 || credit_cnt !== 3'd7) begin
            errors++;
            $display("[TB] FAIL ovf_sticky: got err %b cnt %0d expected 1 7", err_ovf, credit_cnt);
        end
        do_reset();
        checks++;
        if (err_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clear: got %b expected 0", err_ovf);
        end
    endtask

    task automatic test_reset_mid_packet;
        do_reset();
        req = 4'b0001;
        ci  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            fl[0] = (c == 0) ? {2'b10, 18'h0A0A0} : {2'b00, 18'h0B0B0 + 18'(c)};
            #1;
            checks++;
            if (gnt !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL mid_gnt cycle %0d: got %b expected 0001", c, gnt);
            end
            step();
        end
        checks++;
        if (credit_cnt !== 3'd3) begin
            errors++;
            $display("[TB] FAIL mid_credit: got %0d expected 3", credit_cnt);
        end
        rst   = 1'b1;
        req   = 4'b0101;
        fl[2] = {2'b11, 18'h25252};
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_rst_gnt: got %b expected 0000", gnt);
        end
        step();
        checks++;
        if (credit_cnt !== 3'd7 || out_valid !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_rst_state: got cnt %0d valid %b gnt %b expected 7 0 0000",
                     credit_cnt, out_valid, gnt);
        end
        rst = 1'b0;
        req = 4'b0100;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL mid_release_gnt: got %b expected 0100", gnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || dataout !== fl[2]) begin
            errors++;
            $display("[TB] FAIL mid_release_data: got valid %b data %h expected 1 %h",
                     out_valid, dataout, fl[2]);
        end
        req = 4'b0000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        ci     = 1'b0;
        for (int i = 0; i < 4; i++) fl[i] = 20'd0;
        test_reset();
        test_round_robin();
        test_credit_exhaust();
        test_packet_lock();
        test_overflow();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_link_arbiter.md
# pe_link_arbiter

Credit-based round-robin arbiter that shares one 20-bit processing-element injection link between four local flit sources. It sits between the traffic generators inside a processing element and the router's local input port. It grants one source per cycle only when a downstream buffer credit is available, and registers the winning flit onto the link. Credits return on `ci`, one per pulse.

## Interface
- `N_REQ`, 4: number of requesters; fixed at 4 for this revision.
- `CREDITS`, 7: downstream buffer depth; credit counter reset value. Legal range 1..7.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  4  per-source flit valid; `req[i]` held with `flit_i` until granted.
- `flit0`..`flit3`  in  20 each  source flits; bits [19:18] encode flit type: 10 head, 00 body, 01 tail, 11 single.
- `ci`  in  1  credit return, one credit per cycle high.
- `gnt`  out  4  one-hot combinational grant; the flit is consumed in the cycle `gnt[i]` is high.
- `dataout`  out  20  registered link flit.
- `out_valid`  out  1  registered; high for exactly the cycle `dataout` carries a granted flit.
- `credit_cnt`  out  3  current available credits.
- `err_ovf`  out  1  sticky; set when `ci` arrives with `credit_cnt == CREDITS`.

## Operation
- Credit counter `credit_cnt` has the following next-state rules:
  - send only (any `gnt` high, `ci` low): −1.
  - `ci` only: +1.
  - both: unchanged.
  - `ci` at `CREDITS` with no send: hold, set `err_ovf`.
- The counter never goes below 0. No grant is issued when `credit_cnt == 0`, even if `ci` is high that cycle. Credit returned in cycle t is usable in t+1.
- Grant eligibility: `credit_cnt > 0` and `req != 0`.
- Round-robin priority pointer `rr_ptr` (2 bits):
  - The search starts at `rr_ptr`, then `rr_ptr+1`, and wraps modulo 4.
  - After a grant that releases the link, `rr_ptr` becomes the granted index + 1 (mod 4).
- FSM has two states, IDLE and LOCKED, with owner register `own` (2 bits).
  - IDLE: arbitrate among all `req`.
    - Granted head flit: go to LOCKED with `own` = winner.
    - Granted single, body or tail flit: stay in IDLE and advance `rr_ptr`.
  - LOCKED: only `req[own]` is eligible; other requests get no grant.
    - Granted tail or single flit: go to IDLE and set `rr_ptr = own+1`.
    - Head or body flit: stay in LOCKED.
- The output register loads `dataout <= flit[winner]` and `out_valid <= 1` when any grant is high. Otherwise `out_valid <= 0` and `dataout` holds its previous value.
- Reset values:
  - `credit_cnt = CREDITS`, `rr_ptr = 0`, state IDLE, `own = 0`.
  - `dataout = 0`, `out_valid = 0`, `err_ovf = 0`.
  - `gnt = 0` for as long as `rst` is high.
- Reset asserted mid-packet abandons the lock and restores full credits. The downstream side is reset in the same cycle.

## Timing
- Grant is combinational from `req`, `credit_cnt`, state and `rr_ptr` in the same cycle.
- Flit appears on `dataout` with `out_valid` one cycle after its grant.
- Sustained throughput is one flit per cycle while credits are available and `ci` keeps pace.
- With no `ci`, at most `CREDITS` consecutive grants occur, then `gnt` stays 0 until `ci`.
- `err_ovf` is set in the cycle after the offending `ci` and clears only on `rst`.

## Configuration
- `PE_ARB_PKT_LOCK_EN` defined: the IDLE/LOCKED wormhole behaviour above. A packet's flits are never interleaved with another source's flits.
- Undefined: no LOCKED state and flit type bits are ignored. Arbitration is per-flit round-robin, and `rr_ptr` advances after every grant.

## Test plan
- Reset, then `req = 4'b1111` with single flits and `ci` high every cycle → grants go 0,1,2,3,0…; `out_valid` is continuous; `credit_cnt` stays at 7.
- `req[2]` only, 9 single flits, `ci` held low → exactly 7 grants; `credit_cnt` reaches 0; `gnt` is 0 afterwards. One `ci` pulse → exactly one more grant, one cycle after the pulse.
- With lock enabled: source 1 sends head, body, body, tail while `req[3]` is high throughout → `dataout` shows the four source-1 flits contiguously, then source 3 is granted. With lock disabled: sources 1 and 3 alternate.
- `credit_cnt = 0` with `ci` high and `req` high in the same cycle → no grant that cycle; grant in the next cycle; `credit_cnt` goes 0→1→0.
- Pulse `ci` with `credit_cnt = 7` and no requests → `err_ovf` = 1 the next cycle and remains set; `credit_cnt` stays at 7.
- Assert `rst` while LOCKED to source 0 with `credit_cnt = 3` → the next cycle shows IDLE, `credit_cnt = 7`, `out_valid = 0` and `gnt = 0`; after release, `req[2]` is granted immediately.
